// File: rtl/or_stim_sequencer.sv
// or_stim_sequencer: sweeps every WIDTH-bit pattern into an OR gate and counts wrong OR-reductions.
module or_stim_sequencer #(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_start,
  input  logic             in_pause,
  input  logic             in_result,
  output logic [WIDTH-1:0] out_pattern,
  output logic             out_busy,
  output logic             out_done,
  output logic [ERR_W-1:0] out_err_cnt,
  output logic             out_pass
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [WIDTH-1:0] pat_n;
  logic [ERR_W-1:0] err_n;
  logic last, miss;
  always_comb begin
    last = hold_cnt == HW'(HOLD_CYCLES - 1);
    miss = in_result != |out_pattern;
    state_n = state;
    pat_n = out_pattern;
    hold_n = hold_cnt;
    err_n = out_err_cnt;
    case (state)
      IDLE, DONE: if (in_start) begin
        state_n = DRIVE;
        pat_n = '0;
        hold_n = '0;
        err_n = '0;
      end
      DRIVE: if (!in_pause) begin
        if (last) begin
          err_n = (miss && !(&out_err_cnt)) ? out_err_cnt + 1'b1 : out_err_cnt;
          state_n = &out_pattern ? DONE : DRIVE;
          pat_n = &out_pattern ? out_pattern : out_pattern + 1'b1;
          hold_n = '0;
        end else hold_n = hold_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_pattern <= '0;
      hold_cnt <= '0;
      out_err_cnt <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_pass <= 1'b0;
    end else begin
      state <= state_n;
      out_pattern <= pat_n;
      hold_cnt <= hold_n;
      out_err_cnt <= err_n;
      out_busy <= state_n == DRIVE;
      out_done <= state_n == DONE;
      out_pass <= state_n == DONE && err_n == '0;
    end
  end
endmodule

// File: tb/tb_or_stim_sequencer.sv
// tb_or_stim_sequencer: two sequencer configurations checked cycle by cycle against a sweep-position model.
module tb_or_stim_sequencer;
  localparam int W = 3;
  localparam int MAXP = (1 << W) - 1;
  localparam int IDLE = 0, DRV = 1, DN = 2;
  logic clk = 0, rst, start, pause;
  logic [1:0] res;
  logic [W-1:0] pat0, pat1;
  logic busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] err0;
  logic [1:0] err1;
  int mode[2], t[2], err[2];
  int h[2] = '{5, 1};
  int emax[2] = '{255, 3};
  int rmode, n_vec, n_bad;

  or_stim_sequencer #(.WIDTH(W), .HOLD_CYCLES(5), .ERR_W(8)) d0 (
    .clk(clk), .rst(rst), .in_start(start), .in_pause(pause), .in_result(res[0]),
    .out_pattern(pat0), .out_busy(busy0), .out_done(done0), .out_err_cnt(err0), .out_pass(pass0));
  or_stim_sequencer #(.WIDTH(W), .HOLD_CYCLES(1), .ERR_W(2)) d1 (
    .clk(clk), .rst(rst), .in_start(start), .in_pause(pause), .in_result(res[1]),
    .out_pattern(pat1), .out_busy(busy1), .out_done(done1), .out_err_cnt(err1), .out_pass(pass1));

  always #5 clk = ~clk;

  // The sweep position t counts unpaused DRIVE cycles; the pattern is simply t / hold.
  function automatic int mpat(int i);
    return mode[i] == IDLE ? 0 : mode[i] == DN ? MAXP : t[i] / h[i];
  endfunction

  function automatic logic gate(int i);
    int p = mpat(i);
    case (rmode)
      0: return p != 0;
      1: return 1'b0;
      2: return 1'b1;
      3: return p == 0;
      default: return 1'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    res[0] = gate(0);
    res[1] = gate(1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mode[i] = IDLE; t[i] = 0; err[i] = 0;
      end else if (mode[i] != DRV && start) begin
        mode[i] = DRV; t[i] = 0; err[i] = 0;
      end else if (mode[i] == DRV && !pause) begin
        if (t[i] % h[i] == h[i] - 1) begin
          if (res[i] != (mpat(i) != 0) && err[i] < emax[i]) err[i]++;
          if (mpat(i) == MAXP) mode[i] = DN;
        end
        t[i]++;
      end
    end
    #1;
    chk("pattern0", 32'(pat0), 32'(mpat(0)));
    chk("busy0", 32'(busy0), 32'(mode[0] == DRV));
    chk("done0", 32'(done0), 32'(mode[0] == DN));
    chk("err0", 32'(err0), 32'(err[0]));
    chk("pass0", 32'(pass0), 32'(mode[0] == DN && err[0] == 0));
    chk("pattern1", 32'(pat1), 32'(mpat(1)));
    chk("busy1", 32'(busy1), 32'(mode[1] == DRV));
    chk("done1", 32'(done1), 32'(mode[1] == DN));
    chk("err1", 32'(err1), 32'(err[1]));
    chk("pass1", 32'(pass1), 32'(mode[1] == DN && err[1] == 0));
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1; start = 0; pause = 0; rmode = 0; res = 0;
    for (int i = 0; i < 2; i++) begin mode[i] = IDLE; t[i] = 0; err[i] = 0; end
    step(); step();
    rst = 0;
    step();
    rmode = 0; pulse_start(); repeat (45) step();
    rmode = 1; pulse_start(); repeat (45) step();
    rmode = 2; pulse_start(); repeat (45) step();
    rmode = 0; pulse_start(); repeat (16) step();
    pause = 1; repeat (3) step();
    pause = 0; repeat (30) step();
    pulse_start(); repeat (21) step();
    rst = 1; step();
    rst = 0; step();
    pulse_start(); repeat (45) step();
    rmode = 3; pulse_start(); repeat (45) step();
    rmode = 1; pulse_start(); repeat (45) step();
    pulse_start(); repeat (10) step();
    pulse_start(); repeat (40) step();
    start = 1; pause = 1; step();
    start = 0; repeat (3) step();
    pause = 0; repeat (45) step();
    repeat (800) begin
      rst = $urandom % 150 == 0;
      start = $urandom % 25 == 0;
      pause = $urandom % 4 == 0;
      rmode = int'($urandom % 5);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
